// File: rtl/eros_obi_pkg.sv
`default_nettype none
// ============================================================================
// Module : eros_obi_pkg
// Brief  : OBI request/response types and response-pipeline stage type
//          shared by the OBI memory responder.
// Rev    : 1.0  initial release
// ============================================================================
package eros_obi_pkg;

  // Initiator-to-subordinate request channel.
  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  // Subordinate-to-initiator grant and response channel.
  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

  // Read data returned for an access outside the backed window.
  localparam logic [31:0] OBI_OOR_RDATA = 32'hDEAD_BEEF;

  // One slot of the response delay line.
  typedef struct packed {
    logic        valid;
    logic        oor;
    logic [31:0] rdata;
  } obi_rsp_stage_t;

  // Grant FSM states.
  typedef enum logic [0:0] {
    GNT_IDLE = 1'b0,
    GNT_WAIT = 1'b1
  } gnt_state_e;

endpackage
`default_nettype wire

// File: rtl/eros_obi_resp_pipe.sv
`default_nettype none
// ============================================================================
// Module : eros_obi_resp_pipe
// Brief  : Fixed-depth response delay line; every stage advances each cycle,
//          the last stage drives the response outputs.
// Rev    : 1.0  initial release
// ============================================================================
module eros_obi_resp_pipe
  import eros_obi_pkg::*;
#(
  parameter int Depth = 1
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  obi_rsp_stage_t stage_i,
  output obi_rsp_stage_t stage_o
);

  obi_rsp_stage_t stages [Depth];

  // Shift one stage per cycle; reset drops every pending response.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Depth; i++) stages[i] <= '0;
    end else begin
      stages[0] <= stage_i;
      for (int i = 1; i < Depth; i++) stages[i] <= stages[i-1];
    end
  end

  assign stage_o = stages[Depth-1];

endmodule
`default_nettype wire

// File: rtl/eros_obi_mem_responder.sv
`default_nettype none
// ============================================================================
// Module : eros_obi_mem_responder
// Brief  : OBI subordinate backed by a word-organised memory with
//          configurable grant wait states and response latency.
// Rev    : 1.0  initial release
// ============================================================================
module eros_obi_mem_responder
  import eros_obi_pkg::*;
#(
  parameter int unsigned NumWords    = 256,
  parameter logic [31:0] BaseAddr    = 32'h0000_0000,
  parameter int unsigned WaitStates  = 0,
  parameter int unsigned RespLatency = 1
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  obi_req_t  obi_req_i,
  output obi_resp_t obi_resp_o,
  output logic      oor_o
);

  localparam int unsigned IdxW  = $clog2(NumWords);
  localparam logic [32:0] Span  = 33'(NumWords) << 2;
  localparam logic [3:0]  WaitN = 4'(WaitStates);

  gnt_state_e     state, state_next;
  logic [3:0]     cnt, cnt_next;
  logic           gnt_raw;
  logic           gnt;
  logic           accept;

  logic [31:0]    offset;
  logic           in_range;
  logic [IdxW-1:0] index;
  logic           unused_offset;

  logic [31:0]    mem [NumWords];
  obi_rsp_stage_t stage_in;
  obi_rsp_stage_t stage_out;

  // Grant FSM state and wait counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= GNT_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state logic: count wait cycles while req is held, grant on the Nth.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    gnt_raw    = 1'b0;
    if (WaitStates == 0) begin
      gnt_raw    = obi_req_i.req;
      state_next = GNT_IDLE;
      cnt_next   = 4'd0;
    end else begin
      case (state)
        GNT_IDLE: begin
          if (obi_req_i.req) begin
            state_next = GNT_WAIT;
            cnt_next   = 4'd1;
          end
        end
        GNT_WAIT: begin
          if (!obi_req_i.req) begin
            // Request withdrawn: abandon it without a transaction.
            state_next = GNT_IDLE;
            cnt_next   = 4'd0;
          end else if (cnt == WaitN) begin
            gnt_raw    = 1'b1;
            state_next = GNT_IDLE;
            cnt_next   = 4'd0;
          end else begin
            cnt_next = cnt + 4'd1;
          end
        end
        default: begin
          state_next = GNT_IDLE;
          cnt_next   = 4'd0;
        end
      endcase
    end
  end

  // The zero-wait grant is combinational from req, so it is forced low in reset.
  assign gnt    = gnt_raw & rst_ni;
  assign accept = obi_req_i.req & gnt;

  // Address window decode; the subtraction keeps the upper bound overflow-free.
  assign offset        = obi_req_i.addr - BaseAddr;
  assign in_range      = (obi_req_i.addr >= BaseAddr) && ({1'b0, offset} < Span);
  assign index         = offset[IdxW+1:2];
  assign unused_offset = ^offset[1:0];

  // Byte-lane writes at the accepting edge; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (accept && obi_req_i.we && in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (obi_req_i.be[b]) mem[index][8*b +: 8] <= obi_req_i.wdata[8*b +: 8];
      end
    end
  end

  // Response captured at the accepting edge: full word for reads, 0 for writes.
  always_comb begin
    stage_in = '0;
    if (accept) begin
      stage_in.valid = 1'b1;
      stage_in.oor   = !in_range;
      if (!obi_req_i.we) stage_in.rdata = in_range ? mem[index] : OBI_OOR_RDATA;
    end
  end

  eros_obi_resp_pipe #(
    .Depth (int'(RespLatency))
  ) u_resp_pipe (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .stage_i (stage_in),
    .stage_o (stage_out)
  );

  assign obi_resp_o = '{gnt: gnt, rvalid: stage_out.valid, rdata: stage_out.rdata};
  assign oor_o      = stage_out.oor;

endmodule
`default_nettype wire

// File: doc/eros_obi_mem_responder.md
Name: eros_obi_mem_responder

Overview:
OBI subordinate (responder) terminating one OBI port carrying eros_obi_pkg::obi_req_t and obi_resp_t. It backs the port with a word-organised internal memory. Grant wait states and response latency are configurable, so initiators and interconnect can be exercised against realistic memory timing. It is used as the default data/instruction memory model and as a bus-end terminator in subsystem benches and FPGA builds.

Parameters:
NumWords, 256, memory depth in 32-bit words (power of two, >=2)
BaseAddr, 32'h0000_0000, byte address of word 0 (aligned to 4*NumWords)
WaitStates, 0, cycles between first req sample and gnt (0..15)
RespLatency, 1, cycles from accepting edge to rvalid (1..4)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
obi_req_i  in  obi_req_t  req, we, be[3:0], addr[31:0], wdata[31:0] from initiator
obi_resp_o  out  obi_resp_t  gnt, rvalid, rdata[31:0] to initiator
oor_o  out  1  one-cycle pulse, coincident with rvalid, for an out-of-range access

Behaviour:
- Reset, asserted asynchronously: gnt=0, rvalid=0, rdata=0, oor_o=0, FSM=IDLE, wait counter=0, response pipeline flushed. Memory contents are not reset.
- Reset mid-operation: all pending responses are dropped. No rvalid appears after reset release for pre-reset requests.
- Accept = req & gnt, sampled on the rising clk_i edge.
- Grant FSM with states IDLE and WAIT:
  - WaitStates=0: gnt = req combinationally. The FSM stays in IDLE. Back-to-back accepts are allowed every cycle.
  - WaitStates=N>0, in IDLE with req=1: go to WAIT with cnt=1, gnt=0.
  - In WAIT: cnt increments each cycle. gnt=1 in the cycle where cnt==N and req=1. On accept, return to IDLE.
  - req deasserted while in WAIT (protocol violation): go to IDLE, cnt=0, no transaction.
  - After an accept, the next request starts a fresh wait count. N wait states means one accept per N+1 cycles at most.
- Address decode:
  - in_range = addr >= BaseAddr and addr < BaseAddr + 4*NumWords.
  - index = (addr - BaseAddr)[log2(NumWords)+1:2]. addr[1:0] is ignored.
- Write accept:
  - Each byte lane i with be[i]=1 updates mem[index] at the accepting edge.
  - be=0 is a legal no-op write.
  - The response carries rdata=0.
- Read accept:
  - mem[index] is sampled at the accepting edge.
  - be does not mask read data; all 32 bits are returned.
- Read-after-write: a read accepted one cycle after a write to the same word returns the newly written data.
- Out of range:
  - Writes are dropped.
  - Reads return OBI_OOR_RDATA.
  - oor_o pulses together with that response's rvalid.
- Response pipeline:
  - Depth is RespLatency stages; each stage holds {valid, rdata, oor}.
  - rvalid is asserted exactly RespLatency cycles after the accepting edge, for one cycle per accepted transaction, in accept order.
  - rdata is 0 when rvalid=0.
- Outstanding transactions: at most RespLatency outstanding. This is guaranteed because the pipeline advances every cycle; no backpressure exists (no rready).
- A grant and a response in the same cycle are independent and both legal.

Decomposition:
- Add to eros_obi_pkg:
  - localparam OBI_OOR_RDATA = 32'hDEAD_BEEF
  - typedef obi_rsp_stage_t {valid, oor, rdata[31:0]}
- Sub-module eros_obi_resp_pipe:
  - Parameter Depth.
  - Shift register of obi_rsp_stage_t with asynchronous active-low reset to all-zero.
  - Drives rvalid, rdata and oor_o from its last stage.
- The top level holds the grant FSM, address decode and memory array.

Test Plan:
- Defaults (WaitStates=0, RespLatency=1): write addr 0x10, wdata 0xCAFE_F00D, be 4'hF; next cycle read 0x10 -> gnt same cycle as req each time; write rvalid with rdata 0; read rvalid one cycle after its accept with rdata 0xCAFE_F00D.
- Byte enables: mem[4]=0x1122_3344, then write 0xAABB_CCDD with be=4'b0101 to 0x10, then read -> rdata 0x11BB_33DD.
- WaitStates=3, RespLatency=2: req held from cycle 0 -> gnt in cycle 3 only, rvalid in cycle 5; req dropped in cycle 1 -> no gnt, no rvalid, FSM back to IDLE.
- Streaming with RespLatency=4: 8 back-to-back reads of words 0..7 preloaded with i*0x0101_0101 -> 8 consecutive rvalid cycles starting 4 cycles after the first accept, data in order.
- Out of range: read BaseAddr+4*NumWords -> rdata 0xDEAD_BEEF with oor_o=1; write to the same address leaves all words unchanged.
- Reset mid-flight with RespLatency=3: assert rst_ni low one cycle after two accepts -> gnt/rvalid/rdata/oor_o 0 immediately; no rvalid after release; memory retains prior contents.
